// File: rtl/prime_decoder_seq_pkg.sv
// Shared types and constant helpers for the prime decoder.
package prime_dec_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_W = 1 << MAX_N;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  // Trial division up to sqrt(255); only used at elaboration time.
  function automatic logic is_prime(input int code);
    logic res;
    res = (code >= 2);
    for (int d = 2; d < 16; d++) begin
      if ((d * d <= code) && (code % d == 0)) begin
        res = 1'b0;
      end
    end
    return res;
  endfunction

  // Bit i set when i is prime, for every code of an n-bit field.
  function automatic logic [MAX_W-1:0] prime_mask(input int n);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < (1 << n)) begin
        m[i] = is_prime(i);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/prime_decoder_seq_onehot_dec_stage.sv
// Combinational N-to-2^N decoder with enable. The code is split into 2-bit
// digits, each decoded by a 2-to-4 stage; an output bit is the AND of the
// selected line of every digit decoder.
module onehot_dec_stage #(
  parameter int N = 4
) (
  input  logic             en_i,
  input  logic [N-1:0]     code_i,
  output logic [(1<<N)-1:0] onehot_o
);

  localparam int W  = 1 << N;
  localparam int NG = (N + 1) / 2;

  logic [2*NG-1:0] code_pad;
  logic [3:0]      dec [NG];
  logic            bit_v;

  // Zero-extend odd widths to a whole number of 2-bit digits.
  always_comb begin
    code_pad         = '0;
    code_pad[N-1:0]  = code_i;
  end

  // One 2-to-4 stage per digit.
  always_comb begin
    for (int g = 0; g < NG; g++) begin
      dec[g] = 4'b0001 << code_pad[2*g +: 2];
    end
  end

  // Combine digit decodes into the full one-hot word.
  always_comb begin
    onehot_o = '0;
    bit_v    = 1'b0;
    for (int i = 0; i < W; i++) begin
      bit_v = en_i;
      for (int g = 0; g < NG; g++) begin
        bit_v = bit_v & dec[g][2'(i >> (2*g))];
      end
      onehot_o[i] = bit_v;
    end
  end

endmodule

// File: rtl/prime_decoder_seq.sv
// Registered one-hot decoder with prime flag, valid/ready on both sides and
// a sweep mode that walks codes up to 2^N-1 while counting primes.
//
//   state    | meaning
//   ST_IDLE  | single decodes accepted; output drains on handshake
//   ST_SWEEP | output walks code+1 per handshake until 2^N-1
module prime_decoder_seq
  import prime_dec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [(1<<N)-1:0] out_onehot,
  output logic [N-1:0]      out_code,
  output logic              out_prime,
  output logic [N-1:0]      prime_count,
  output logic              sweep_done
);

  localparam int W = 1 << N;
  localparam logic [W-1:0] PRIME_MASK = W'(prime_mask(N));

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_code_q, out_code_d;
  logic [W-1:0]   out_onehot_q, onehot_next;
  logic           out_prime_q, out_prime_d;
  logic [N-1:0]   prime_count_q, prime_count_d;
  logic           sweep_done_q, sweep_done_d;
  logic           accept;
  logic           out_hs;

  // The done cycle also blocks input so the pulse is seen before a new job.
  assign in_ready = en & (state_q == ST_IDLE) & ~sweep_done_q
                  & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;

  // Decode the next code so the one-hot word is registered with it.
  onehot_dec_stage #(.N(N)) u_dec (
    .en_i     (out_valid_d),
    .code_i   (out_code_d),
    .onehot_o (onehot_next)
  );

  // Next-state, output-register and counter logic; en=0 holds everything.
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_code_d    = out_code_q;
    prime_count_d = prime_count_q;
    sweep_done_d  = sweep_done_q;
    if (en) begin
      sweep_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_code_d  = in_code;
            out_valid_d = 1'b1;
            if (mode) begin
              prime_count_d = '0;
              state_d       = ST_SWEEP;
            end
          end else if (out_hs) begin
            out_valid_d = 1'b0;
          end
        end
        ST_SWEEP: begin
          if (out_hs) begin
            prime_count_d = prime_count_q + N'(out_prime_q);
            if (out_code_q == '1) begin
              out_valid_d  = 1'b0;
              sweep_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              out_code_d = out_code_q + N'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    out_prime_d = out_valid_d & PRIME_MASK[out_code_d];
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      out_code_q    <= '0;
      out_onehot_q  <= '0;
      out_prime_q   <= 1'b0;
      prime_count_q <= '0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_code_q    <= out_code_d;
      out_onehot_q  <= onehot_next;
      out_prime_q   <= out_prime_d;
      prime_count_q <= prime_count_d;
      sweep_done_q  <= sweep_done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_code    = out_code_q;
  assign out_onehot  = out_onehot_q;
  assign out_prime   = out_prime_q;
  assign prime_count = prime_count_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_prime_decoder_seq.sv
// Bench for prime_decoder_seq: N=4 instance checked every cycle against a
// queue-based model of the presented code stream, plus an N=8 full sweep.
module tb_prime_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  // N=4 instance
  logic        en = 1'b1, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic [3:0]  in_code = '0;
  logic        in_ready, out_valid, out_prime, sweep_done;
  logic [15:0] out_onehot;
  logic [3:0]  out_code, prime_count;

  prime_decoder_seq #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_code(out_code), .out_prime(out_prime),
    .prime_count(prime_count), .sweep_done(sweep_done)
  );

  // N=8 instance
  logic         en8 = 1'b1, in_valid8 = 1'b0, mode8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]   in_code8 = '0;
  logic         in_ready8, out_valid8, out_prime8, sweep_done8;
  logic [255:0] out_onehot8;
  logic [7:0]   out_code8, prime_count8;

  prime_decoder_seq #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_code(in_code8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_onehot(out_onehot8), .out_code(out_code8), .out_prime(out_prime8),
    .prime_count(prime_count8), .sweep_done(sweep_done8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit tb_is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d < v; d++) if (v % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- model of the N=4 instance ----------------
  bit   chk_on = 1'b0;
  int   mq[$];
  int   m_pc = 0;
  bit   m_sweep = 1'b0;
  bit   m_done = 1'b0;
  bit   exp_valid, exp_ready, nd;
  int   c;
  logic [15:0] exp_oh;

  // Compare first, then advance the model to what the next edge will do.
  always @(negedge clk) begin
    if (chk_on) begin
      exp_valid = (mq.size() > 0);
      exp_ready = en && !m_sweep && !m_done && (!exp_valid || out_ready);
      check("out_valid", out_valid, exp_valid);
      check("in_ready", in_ready, exp_ready);
      check("sweep_done", sweep_done, m_done);
      check("prime_count", prime_count, m_pc);
      if (exp_valid) begin
        exp_oh = 16'd1 << mq[0];
        check("out_code", out_code, mq[0]);
        check("out_onehot", out_onehot, exp_oh);
        check("out_prime", out_prime, tb_is_prime(mq[0]));
      end else begin
        check("out_onehot_idle", out_onehot, 0);
        check("out_prime_idle", out_prime, 0);
      end

      if (!rst_n) begin
        mq.delete();
        m_pc = 0; m_sweep = 1'b0; m_done = 1'b0;
      end else if (en) begin
        nd = 1'b0;
        if (exp_valid && out_ready) begin
          c = mq.pop_front();
          if (m_sweep) begin
            m_pc += int'(tb_is_prime(c));
            if (c == 15) begin m_sweep = 1'b0; nd = 1'b1; end
          end
        end
        if (in_valid && exp_ready) begin
          if (mode) begin
            m_pc = 0; m_sweep = 1'b1;
            for (int v = int'(in_code); v < 16; v++) mq.push_back(v);
          end else begin
            mq.push_back(int'(in_code));
          end
        end
        m_done = nd;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_accept();
    int n = 0;
    bit ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_valid && in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [3:0] code);
    in_code = code; mode = 1'b0; in_valid = 1'b1;
    wait_accept();
  endtask

  // Runs a sweep to sweep_done; returns negedges from acceptance to done.
  task automatic sweep(input logic [3:0] s, input bit rnd, output int cyc, output int pc);
    bit done = 1'b0;
    in_code = s; mode = 1'b1; in_valid = 1'b1;
    wait_accept();
    mode = 1'b0;
    cyc = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sweep_done) begin done = 1'b1; pc = int'(prime_count); end
      step();
      if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
        en = !(cyc >= 5 && cyc < 9);
      end
    end
    en = 1'b1; out_ready = 1'b1;
    if (!done) begin check("sweep_timeout", 0, 1); pc = -1; end
  endtask

  int cyc, pc, n8, mpc;
  bit done8;

  initial begin
    // Model pins: 6 primes below 16, 54 below 256.
    mpc = 0; for (int i = 0; i < 16; i++) mpc += int'(tb_is_prime(i));
    check("model_primes16", mpc, 6);
    mpc = 0; for (int i = 0; i < 256; i++) mpc += int'(tb_is_prime(i));
    check("model_primes256", mpc, 54);

    repeat (3) step();
    rst_n = 1'b1; chk_on = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_onehot", out_onehot, 0);
    check("rst_code", out_code, 0);
    check("rst_pc", prime_count, 0);
    step();

    // single decodes
    send(4'd5);
    @(negedge clk);
    check("code5_onehot", out_onehot, 16'h0020);
    check("code5_prime", out_prime, 1);
    step();
    send(4'd9);
    @(negedge clk);
    check("code9_onehot", out_onehot, 16'h0200);
    check("code9_prime", out_prime, 0);
    step();
    repeat (2) step();

    // back-to-back with stall on code 3
    send(4'd2);
    send(4'd3);
    out_ready = 1'b0; in_code = 4'd4; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_code", out_code, 3);
      check("stall_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    wait_accept();
    @(negedge clk);
    check("after_stall_code", out_code, 4);
    step();
    repeat (2) step();

    // sweeps
    sweep(4'd0, 1'b0, cyc, pc);
    check("sweep0_pc", pc, 6);
    check("sweep0_cycles", cyc, 17);
    sweep(4'd13, 1'b0, cyc, pc);
    check("sweep13_pc", pc, 1);
    check("sweep13_cycles", cyc, 4);
    sweep(4'd15, 1'b0, cyc, pc);
    check("sweep15_pc", pc, 0);
    check("sweep15_cycles", cyc, 2);
    step();

    // sweep with en gap and random out_ready
    sweep(4'd0, 1'b1, cyc, pc);
    check("sweep_rnd_pc", pc, 6);
    step();

    // reset in the middle of a sweep
    in_code = 4'd0; mode = 1'b1; in_valid = 1'b1;
    wait_accept();
    mode = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (out_code != 4'd6 && cyc < 40);
    if (cyc >= 40) check("reach_code6_timeout", 0, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_code", out_code, 0);
    check("mid_rst_onehot", out_onehot, 0);
    check("mid_rst_pc", prime_count, 0);
    check("mid_rst_done", sweep_done, 0);
    step();
    repeat (3) step();
    send(4'd11);
    @(negedge clk);
    check("post_rst_onehot", out_onehot, 16'h0800);
    check("post_rst_prime", out_prime, 1);
    step();
    repeat (2) step();

    // N=8 full sweep
    in_code8 = 8'd0; mode8 = 1'b1; in_valid8 = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; done8 = in_ready8; step(); end while (!done8 && cyc < 50);
    in_valid8 = 1'b0; mode8 = 1'b0;
    if (!done8) check("accept8_timeout", 0, 1);
    n8 = 0; done8 = 1'b0; cyc = 0;
    while (!done8 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (out_valid8) begin
        check("n8_code", out_code8, n8);
        check("n8_prime", out_prime8, tb_is_prime(n8));
        if (n8 == 255) check("n8_bit255", out_onehot8[255], 1);
        n8++;
      end
      if (sweep_done8) begin
        done8 = 1'b1;
        check("n8_pc", prime_count8, 54);
      end
      step();
    end
    check("n8_outputs", n8, 256);
    check("n8_done_seen", done8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
